serial_ripple_subtractor: RTL



---
 rtl/serial_sub_pkg.sv | 17 +
 rtl/serial_ripple_subtractor_fs.sv | 17 +
 rtl/serial_ripple_subtractor.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// FSM state encoding, default width, counter-width helper.
package serial_sub_pkg;

  localparam int SUB_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } sub_state_e;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_ripple_subtractor_fs.sv
// One-bit full-subtractor cell: d = a - b - bin, bout = borrow.
// Ports: a, b, bin in; d, bout out (all 1 bit, combinational).
module full_subtractor_struc (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic axb;

  assign axb  = a ^ b;
  assign d    = axb ^ bin;
  assign bout = (~a & b) | (~axb & bin);

endmodule

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock, start/busy/done.
// Ports: clk, rst (sync, active-high), start, a, b, bin in;
//        busy, done, diff, bout out; ovf out with SERIAL_SUB_OVF_EN.
module serial_ripple_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
    $error("WIDTH must be in 2..16");
  end

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic fs_d;
  logic fs_b;

  full_subtractor_struc u_fs (
    .a    (ra_q[0]),
    .b    (rb_q[0]),
    .bin  (br_q),
    .d    (fs_d),
    .bout (fs_b)
  );

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    part_d  = part_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          ra_d    = a;
          rb_d    = b;
          br_d    = bin;
          part_d  = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        part_d = {fs_d, part_q[WIDTH-1:1]};
        ra_d   = ra_q >> 1;
        rb_d   = rb_q >> 1;
        br_d   = fs_b;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Result goes straight from the cell to the output regs,
          // so partial values never appear on diff.
          state_d = ST_DONE;
          diff_d  = {fs_d, part_q[WIDTH-1:1]};
          bout_d  = fs_b;
`ifdef SERIAL_SUB_OVF_EN
          // br_q is the borrow into the MSB, fs_b the borrow out.
          ovf_d   = br_q ^ fs_b;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      part_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      part_q  <= part_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_DONE);
  assign diff = diff_q;
  assign bout = bout_q;

endmodule
